// File: rtl/croc_pkg.sv
// rtl/croc_pkg.sv - OBI subordinate and regbus types shared by the croc peripheral bridges.
package croc_pkg;

  localparam int unsigned SbrAidWidth = 3;

  // Read data returned when a peripheral never answers (timeout build only).
  localparam logic [31:0] RegBridgeTimeoutData = 32'hBADC_AB1E;

  typedef struct packed {
    logic                   req;
    logic [31:0]            addr;
    logic                   we;
    logic [3:0]             be;
    logic [31:0]            wdata;
    logic [SbrAidWidth-1:0] aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic                   gnt;
    logic                   rvalid;
    logic [31:0]            rdata;
    logic [SbrAidWidth-1:0] rid;
    logic                   err;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    BridgeIdle   = 2'd0,
    BridgeAccess = 2'd1,
    BridgeResp   = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/croc_obi_reg_bridge.sv
// rtl/croc_obi_reg_bridge.sv - one-at-a-time OBI subordinate to regbus converter.
// Optional regbus wait timeout: CROC_OBI_REG_BRIDGE_TIMEOUT_EN.
module croc_obi_reg_bridge
  import croc_pkg::*;
#(
  parameter type         obi_req_t     = croc_pkg::sbr_obi_req_t,
  parameter type         obi_rsp_t     = croc_pkg::sbr_obi_rsp_t,
  parameter type         reg_req_t     = croc_pkg::reg_req_t,
  parameter type         reg_rsp_t     = croc_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  output logic     busy_o
);

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end

  bridge_state_e          state_q, state_d;
  logic [31:0]            addr_q, wdata_q, rdata_q, rdata_d;
  logic                   we_q, err_q, err_d;
  logic [3:0]             be_q;
  logic [SbrAidWidth-1:0] aid_q;
  logic                   accept, done, timeout;

  // Grant is offered whenever no access is outstanding, including the RESP beat.
  assign accept = obi_req_i.req && (state_q != BridgeAccess);

`ifdef CROC_OBI_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == BridgeAccess) && !reg_rsp_i.ready &&
                   (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == BridgeAccess && !reg_rsp_i.ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign done = (state_q == BridgeAccess) && (reg_rsp_i.ready || timeout);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BridgeIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BridgeIdle:   if (accept) state_d = BridgeAccess;
      BridgeAccess: if (done) state_d = BridgeResp;
      BridgeResp:   state_d = accept ? BridgeAccess : BridgeIdle;
      default:      state_d = BridgeIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (done) begin
      if (reg_rsp_i.ready) begin
        rdata_d = we_q ? 32'h0 : reg_rsp_i.rdata;
        err_d   = reg_rsp_i.error;
      end else begin
        rdata_d = RegBridgeTimeoutData;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= obi_req_i.addr;
        wdata_q <= obi_req_i.wdata;
        we_q    <= obi_req_i.we;
        be_q    <= obi_req_i.be;
        aid_q   <= obi_req_i.aid;
      end
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // rst_ni gating keeps gnt quiet while reset is held even if the crossbar requests.
  always_comb begin
    obi_rsp_o        = '0;
    reg_req_o        = '0;
    obi_rsp_o.gnt    = accept && rst_ni;
    obi_rsp_o.rvalid = (state_q == BridgeResp);
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.rid    = aid_q;
    obi_rsp_o.err    = err_q;
    reg_req_o.valid  = (state_q == BridgeAccess);
    reg_req_o.addr   = addr_q;
    reg_req_o.write  = we_q;
    reg_req_o.wdata  = wdata_q;
    reg_req_o.wstrb  = we_q ? be_q : 4'h0;
    busy_o           = (state_q != BridgeIdle);
  end

endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// tb/tb_croc_obi_reg_bridge.sv - bench for croc_obi_reg_bridge with a transaction-level model.
module tb_croc_obi_reg_bridge;
  import croc_pkg::*;

  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  sbr_obi_req_t obi_req = '0;
  sbr_obi_rsp_t obi_rsp;
  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp = '0;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  croc_obi_reg_bridge #(.TimeoutCycles(TO)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .obi_req_i(obi_req),
    .obi_rsp_o(obi_rsp),
    .reg_req_o(reg_req),
    .reg_rsp_i(reg_rsp),
    .busy_o   (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peripheral: answers after wait_cycles stall cycles of valid.
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        force_ready = 1'b0;
  logic [31:0] per_rdata = '0;
  logic        per_err = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reg_req.valid) begin
      reg_rsp.ready = (wcnt == wait_cycles) || force_ready;
      wcnt = reg_rsp.ready ? 0 : wcnt + 1;
    end else begin
      reg_rsp.ready = force_ready;
      wcnt = 0;
    end
    reg_rsp.rdata = per_rdata;
    reg_rsp.error = per_err;
  end

  // Model: at most one granted transaction awaiting the peripheral, then one response beat.
  typedef struct {
    logic [31:0]            addr;
    logic                   we;
    logic [3:0]             be;
    logic [31:0]            wdata;
    logic [SbrAidWidth-1:0] aid;
  } txn_t;

  txn_t                   m_cur;
  bit                     m_pend = 0;
  bit                     m_rsp_v = 0;
  logic [31:0]            m_rsp_data;
  logic                   m_rsp_err;
  logic [SbrAidWidth-1:0] m_rsp_id;
  int                     m_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  = 0;
      m_rsp_v = 0;
    end else begin
      bit g;
      bit fin;
      cyc++;
      g = obi_req.req && !m_pend;
      fin = 0;
      m_rsp_v = 0;
      if (m_pend) begin
        m_wait++;
        if (reg_rsp.ready) begin
          fin = 1;
          m_rsp_data = m_cur.we ? 32'h0 : reg_rsp.rdata;
          m_rsp_err  = reg_rsp.error;
        end
`ifdef CROC_OBI_REG_BRIDGE_TIMEOUT_EN
        else if (m_wait == TO) begin
          fin = 1;
          m_rsp_data = 32'hBADC_AB1E;
          m_rsp_err  = 1'b1;
        end
`endif
        if (fin) begin
          m_rsp_v  = 1;
          m_rsp_id = m_cur.aid;
          m_pend   = 0;
        end
      end
      if (g) begin
        m_cur  = '{obi_req.addr, obi_req.we, obi_req.be, obi_req.wdata, obi_req.aid};
        m_pend = 1;
        m_wait = 0;
      end
    end
  end

  typedef struct {
    int                     c;
    logic [SbrAidWidth-1:0] rid;
    logic [31:0]            rdata;
    logic                   err;
  } rv_t;

  rv_t  rv_q[$];
  int   gnt_q[$];
  int   valid_cnt = 0;
  logic [3:0] last_wstrb = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt", obi_rsp.gnt, obi_req.req && !m_pend);
      check("rvalid", obi_rsp.rvalid, m_rsp_v);
      check("reg_valid", reg_req.valid, m_pend);
      check("busy", busy, m_pend || m_rsp_v);
      if (m_pend) begin
        check("reg_addr", reg_req.addr, m_cur.addr);
        check("reg_write", reg_req.write, m_cur.we);
        check("reg_wdata", reg_req.wdata, m_cur.wdata);
        check("reg_wstrb", reg_req.wstrb, m_cur.we ? m_cur.be : 4'h0);
      end
      if (m_rsp_v) begin
        check("rid", obi_rsp.rid, m_rsp_id);
        check("rdata", obi_rsp.rdata, m_rsp_data);
        check("err", obi_rsp.err, m_rsp_err);
      end
      if (obi_rsp.gnt) gnt_q.push_back(cyc);
      if (reg_req.valid) begin
        valid_cnt++;
        last_wstrb = reg_req.wstrb;
      end
      if (obi_rsp.rvalid) rv_q.push_back('{cyc, obi_rsp.rid, obi_rsp.rdata, obi_rsp.err});
    end
  end

  task automatic clear_logs();
    rv_q.delete();
    gnt_q.delete();
    valid_cnt = 0;
  endtask

  task automatic wait_gnt(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obi_rsp.gnt) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no gnt within 40 cycles", name);
  endtask

  task automatic wait_rv(input int n, input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (rv_q.size() >= n) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %0d rvalid beats seen, wanted %0d", name, rv_q.size(), n);
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [SbrAidWidth-1:0] aid, input string name);
    @(posedge clk);
    #1;
    obi_req = '{req: 1'b1, addr: addr, we: we, be: be, wdata: wdata, aid: aid};
    wait_gnt(name);
    @(posedge clk);
    #1;
    obi_req.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", obi_rsp.gnt, 0);
    check("rst_rvalid", obi_rsp.rvalid, 0);
    check("rst_rdata", obi_rsp.rdata, 0);
    check("rst_rid", obi_rsp.rid, 0);
    check("rst_err", obi_rsp.err, 0);
    check("rst_valid", reg_req.valid, 0);
    check("rst_addr", reg_req.addr, 0);
    check("rst_wdata", reg_req.wdata, 0);
    check("rst_wstrb", reg_req.wstrb, 0);
    check("rst_write", reg_req.write, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait read
    clear_logs();
    wait_cycles = 0;
    per_rdata = 32'h1234_5678;
    issue(32'h0300_2000, 1'b0, 4'hF, 32'h0, 3'd2, "t1");
    wait_rv(1, "t1");
    if (rv_q.size() >= 1 && gnt_q.size() >= 1) begin
      check("t1_latency", rv_q[0].c - gnt_q[0], 2);
      check("t1_rid", rv_q[0].rid, 2);
      check("t1_rdata", rv_q[0].rdata, 32'h1234_5678);
      check("t1_err", rv_q[0].err, 0);
    end
    repeat (3) @(posedge clk);

    // Write with three wait cycles
    clear_logs();
    wait_cycles = 3;
    issue(32'h0300_5004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 3'd1, "t2");
    wait_rv(1, "t2");
    check("t2_valid_cycles", valid_cnt, 4);
    check("t2_wstrb", last_wstrb, 4'b0011);
    if (rv_q.size() >= 1) begin
      check("t2_rdata", rv_q[0].rdata, 32'h0);
      check("t2_err", rv_q[0].err, 0);
      check("t2_rid", rv_q[0].rid, 1);
    end
    repeat (3) @(posedge clk);

    // Back-to-back with request held high
    clear_logs();
    wait_cycles = 0;
    per_rdata = 32'h0000_00C3;
    @(posedge clk);
    #1;
    obi_req = '{req: 1'b1, addr: 32'h0300_1000, we: 1'b0, be: 4'hF, wdata: 32'h0, aid: 3'd0};
    for (int k = 0; k < 3; k++) begin
      wait_gnt("t3_gnt");
      @(posedge clk);
      #1;
      if (k < 2) obi_req.aid = SbrAidWidth'(k + 1);
      else obi_req.req = 1'b0;
    end
    wait_rv(3, "t3");
    if (gnt_q.size() == 3 && rv_q.size() == 3) begin
      check("t3_gnt_gap0", gnt_q[1] - gnt_q[0], 2);
      check("t3_gnt_gap1", gnt_q[2] - gnt_q[1], 2);
      for (int k = 0; k < 3; k++) begin
        check("t3_rid", rv_q[k].rid, k);
        check("t3_latency", rv_q[k].c - gnt_q[k], 2);
      end
    end else begin
      check("t3_counts", {gnt_q.size(), rv_q.size()}, {3, 3});
    end
    repeat (3) @(posedge clk);

    // Peripheral error on read
    clear_logs();
    per_err = 1'b1;
    per_rdata = 32'hDEAD_BEEF;
    issue(32'h0300_3008, 1'b0, 4'hF, 32'h0, 3'd3, "t4");
    wait_rv(1, "t4");
    if (rv_q.size() >= 1) begin
      check("t4_err", rv_q[0].err, 1);
      check("t4_rid", rv_q[0].rid, 3);
      check("t4_rdata", rv_q[0].rdata, 32'hDEAD_BEEF);
    end
    per_err = 1'b0;
    repeat (3) @(posedge clk);

    // Reset during a stalled access
    clear_logs();
    wait_cycles = 10;
    issue(32'h0300_4000, 1'b0, 4'hF, 32'h0, 3'd1, "t5");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_valid_drop", reg_req.valid, 0);
    check("t5_busy_drop", busy, 0);
    check("t5_rvalid", obi_rsp.rvalid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    check("t5_no_rsp", rv_q.size(), 0);
    wait_cycles = 0;
    per_rdata = 32'h0BAD_F00D;
    issue(32'h0300_4004, 1'b0, 4'hF, 32'h0, 3'd2, "t5b");
    wait_rv(1, "t5b");
    if (rv_q.size() >= 1) begin
      check("t5b_rid", rv_q[0].rid, 2);
      check("t5b_rdata", rv_q[0].rdata, 32'h0BAD_F00D);
    end
    repeat (3) @(posedge clk);

`ifdef CROC_OBI_REG_BRIDGE_TIMEOUT_EN
    // Silent peripheral, then a stray late ready
    clear_logs();
    wait_cycles = 1000;
    issue(32'h0300_6000, 1'b0, 4'hF, 32'h0, 3'd5, "t6");
    wait_rv(1, "t6");
    check("t6_valid_cycles", valid_cnt, TO);
    if (rv_q.size() >= 1) begin
      check("t6_err", rv_q[0].err, 1);
      check("t6_rdata", rv_q[0].rdata, 32'hBADC_AB1E);
      check("t6_rid", rv_q[0].rid, 5);
    end
    @(posedge clk);
    #1 force_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 force_ready = 1'b0;
    repeat (2) @(posedge clk);
    check("t6_late_ready_rsp", rv_q.size(), 1);
    check("t6_late_ready_valid", valid_cnt, TO);
    wait_cycles = 0;
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
